// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited word reads to
// instruction memory, and queues tagged responses for decode.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int            CW      = $clog2(BUF_DEPTH + 1);
   localparam int            PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [PW-1:0] LAST    = PW'(BUF_DEPTH - 1);
   localparam logic [CW:0]   DEPTH_C = (CW + 1)'(BUF_DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   buf_pc    [BUF_DEPTH];
   logic [31:0]   buf_instr [BUF_DEPTH];
   logic [31:0]   tag_pc    [BUF_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
   logic [CW-1:0] count, outstanding, drop;

   logic          pop, req_fire, resp_keep;
   logic [CW:0]   credit;
   logic          unused_low_bits;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign pop       = instr_valid && instr_ready;
   assign credit    = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
   // Gating with rst_n keeps the request quiet while reset is held.
   assign imem_req_valid = rst_n && !redirect_valid && (credit < DEPTH_C);
   assign imem_req_addr  = fetch_pc;
   assign req_fire  = imem_req_valid && imem_req_ready;
   assign resp_keep = imem_resp_valid && (drop == '0) && !redirect_valid;

   assign instr_valid = (count != '0);
   assign instr       = buf_instr[rd_ptr];
   assign instr_pc    = buf_pc[rd_ptr];

   assign unused_low_bits = ^redirect_pc[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
         // NOTE: these arrays are only BUF_DEPTH flops deep, so they are reset
         // to give instr/instr_pc a defined zero value out of reset.
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_pc[i]    <= '0;
            buf_instr[i] <= '0;
            tag_pc[i]    <= '0;
         end
      end else begin
         // The tag FIFO tracks the memory, so it advances even across redirects.
         if (req_fire) begin
            tag_pc[tag_wr] <= fetch_pc;
            tag_wr         <= next_ptr(tag_wr);
         end
         if (imem_resp_valid)
            tag_rd <= next_ptr(tag_rd);
         outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);

         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            drop     <= outstanding - CW'(imem_resp_valid);
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + 32'd4;
            if (imem_resp_valid && (drop != '0))
               drop <= drop - 1'b1;
            if (resp_keep) begin
               buf_pc[wr_ptr]    <= tag_pc[tag_rd];
               buf_instr[wr_ptr] <= imem_resp_data;
               wr_ptr            <= next_ptr(wr_ptr);
            end
            if (pop)
               rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(resp_keep) - CW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle in-order instruction memory model
// and a decode-side capture queue.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          acc_cnt = 0;
   bit          mem_hold = 1'b0;
   logic [31:0] pend[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_instr[$];
   int          got_cyc[$];
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // One clock: sample handshakes at the falling edge, then advance the memory.
   task automatic step();
      logic        acc;
      logic [31:0] acc_addr;
      logic        fire;
      @(negedge clk);
      acc      = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      fire     = imem_resp_valid;
      if (instr_valid && instr_ready && !redirect_valid) begin
         got_pc.push_back(instr_pc);
         got_instr.push_back(instr);
         got_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (fire && pend.size() > 0) void'(pend.pop_front());
      if (acc) begin
         pend.push_back(acc_addr);
         acc_cnt++;
      end
      imem_resp_valid = (pend.size() > 0) && !mem_hold;
      imem_resp_data  = (pend.size() > 0) ? mem_word(pend[0]) : 32'h0;
      #1;
   endtask

   task automatic collect(input int n, output bit ok);
      int budget = 40;
      while (got_pc.size() < n && budget > 0) begin
         step();
         budget--;
      end
      ok = (got_pc.size() >= n);
   endtask

   task automatic clear_got();
      got_pc.delete();
      got_instr.delete();
      got_cyc.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
      instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      #2;
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b want=0", instr_valid); end
      total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", imem_req_addr); end
      total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr); end
      total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc got=%h want=0", instr_pc); end
      @(posedge clk); #2;
      rst_n = 1'b1;
      #1;
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         bad++; $display("FAIL first_req got valid=%b addr=%h want 1/0", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_mem_stall();
      int  n = 0;
      bit  ok;
      logic [31:0] pc, ins;
      exp_pc = 32'h0;
      clear_got();
      while (imem_req_addr !== 32'h10 && n < 20) begin step(); n++; end
      total++; if (imem_req_addr !== 32'h10) begin bad++; $display("FAIL stall_reach addr=%h want=10", imem_req_addr); end
      imem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
            bad++; $display("FAIL stall_hold[%0d] valid=%b addr=%h want 1/10", i, imem_req_valid, imem_req_addr);
         end
      end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stall_drained instr_valid=%b want=0", instr_valid); end
      imem_req_ready = 1'b1;
      collect(6, ok);
      total++; if (!ok) begin bad++; $display("FAIL stall_collect got=%0d want=6", got_pc.size()); end
      while (got_pc.size() > 0) begin
         pc = got_pc.pop_front(); ins = got_instr.pop_front();
         total++; if (pc !== exp_pc || ins !== mem_word(exp_pc)) begin
            bad++; $display("FAIL stall_item pc=%h instr=%h want pc=%h instr=%h", pc, ins, exp_pc, mem_word(exp_pc));
         end
         exp_pc += 32'd4;
      end
      clear_got();
   endtask

   task automatic test_sequential();
      bit ok;
      logic [31:0] pc, ins;
      clear_got();
      collect(8, ok);
      total++; if (!ok) begin bad++; $display("FAIL seq_collect got=%0d want=8", got_pc.size()); end
      for (int i = 1; i < got_cyc.size(); i++) begin
         total++; if (got_cyc[i] - got_cyc[i-1] !== 1) begin
            bad++; $display("FAIL seq_rate[%0d] gap=%0d want=1", i, got_cyc[i] - got_cyc[i-1]);
         end
      end
      while (got_pc.size() > 0) begin
         pc = got_pc.pop_front(); ins = got_instr.pop_front();
         total++; if (pc !== exp_pc || ins !== mem_word(exp_pc)) begin
            bad++; $display("FAIL seq_item pc=%h instr=%h want pc=%h instr=%h", pc, ins, exp_pc, mem_word(exp_pc));
         end
         exp_pc += 32'd4;
      end
      clear_got();
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [31:0] pc, ins;
      clear_got();
      instr_ready = 1'b0;
      acc_cnt = 0;
      repeat (5) step();
      total++; if (acc_cnt !== 0) begin bad++; $display("FAIL bp_accepts got=%0d want=0", acc_cnt); end
      total++; if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
         bad++; $display("FAIL bp_full instr_valid=%b req_valid=%b want 1/0", instr_valid, imem_req_valid);
      end
      total++; if (got_pc.size() !== 0) begin bad++; $display("FAIL bp_no_consume got=%0d want=0", got_pc.size()); end
      instr_ready = 1'b1;
      collect(6, ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_collect got=%0d want=6", got_pc.size()); end
      while (got_pc.size() > 0) begin
         pc = got_pc.pop_front(); ins = got_instr.pop_front();
         total++; if (pc !== exp_pc || ins !== mem_word(exp_pc)) begin
            bad++; $display("FAIL bp_item pc=%h instr=%h want pc=%h instr=%h", pc, ins, exp_pc, mem_word(exp_pc));
         end
         exp_pc += 32'd4;
      end
      clear_got();
   endtask

   task automatic test_redirect_inflight();
      bit ok;
      logic [31:0] pc, ins;
      mem_hold = 1'b1;
      repeat (6) step();
      total++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL rd_two_inflight req_valid=%b instr_valid=%b want 0/0", imem_req_valid, instr_valid);
      end
      redirect_pc = 32'h0000_0103;
      redirect_valid = 1'b1;
      #1;
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rd_cycle_req got=%b want=0", imem_req_valid); end
      step();
      redirect_valid = 1'b0;
      #1;
      total++; if (imem_req_addr !== 32'h100 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL rd_after addr=%h instr_valid=%b want 100/0", imem_req_addr, instr_valid);
      end
      mem_hold = 1'b0;
      clear_got();
      exp_pc = 32'h100;
      collect(4, ok);
      total++; if (!ok) begin bad++; $display("FAIL rd_collect got=%0d want=4", got_pc.size()); end
      while (got_pc.size() > 0) begin
         pc = got_pc.pop_front(); ins = got_instr.pop_front();
         total++; if (pc !== exp_pc || ins !== mem_word(exp_pc)) begin
            bad++; $display("FAIL rd_item pc=%h instr=%h want pc=%h instr=%h", pc, ins, exp_pc, mem_word(exp_pc));
         end
         exp_pc += 32'd4;
      end
      clear_got();
   endtask

   task automatic test_wrap();
      bit ok;
      logic [31:0] pc, ins;
      logic [31:0] want [4];
      want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0; want[3] = 32'h4;
      redirect_pc = 32'hFFFF_FFFA;
      redirect_valid = 1'b1;
      step();
      redirect_valid = 1'b0;
      #1;
      total++; if (imem_req_addr !== 32'hFFFF_FFF8 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL wrap_redirect addr=%h instr_valid=%b want fffffff8/0", imem_req_addr, instr_valid);
      end
      clear_got();
      collect(4, ok);
      total++; if (!ok) begin bad++; $display("FAIL wrap_collect got=%0d want=4", got_pc.size()); end
      for (int i = 0; i < 4 && got_pc.size() > 0; i++) begin
         pc = got_pc.pop_front(); ins = got_instr.pop_front();
         total++; if (pc !== want[i] || ins !== mem_word(want[i])) begin
            bad++; $display("FAIL wrap_item[%0d] pc=%h instr=%h want pc=%h instr=%h", i, pc, ins, want[i], mem_word(want[i]));
         end
      end
      clear_got();
   endtask

   task automatic test_reset_midstream();
      int  n = 0;
      bit  ok;
      logic [31:0] pc, ins;
      instr_ready = 1'b0;
      while (!(instr_valid === 1'b1 && imem_req_valid === 1'b0) && n < 8) begin step(); n++; end
      total++; if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
         bad++; $display("FAIL mr_full instr_valid=%b req_valid=%b want 1/0", instr_valid, imem_req_valid);
      end
      #1;
      rst_n = 1'b0;
      pend.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      #1;
      total++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         bad++; $display("FAIL mr_async instr_valid=%b req_valid=%b want 0/0", instr_valid, imem_req_valid);
      end
      total++; if (instr_pc !== 32'h0 || imem_req_addr !== 32'h0) begin
         bad++; $display("FAIL mr_state instr_pc=%h addr=%h want 0/0", instr_pc, imem_req_addr);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;
      instr_ready = 1'b1;
      #1;
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         bad++; $display("FAIL mr_restart valid=%b addr=%h want 1/0", imem_req_valid, imem_req_addr);
      end
      clear_got();
      exp_pc = 32'h0;
      collect(3, ok);
      total++; if (!ok) begin bad++; $display("FAIL mr_collect got=%0d want=3", got_pc.size()); end
      while (got_pc.size() > 0) begin
         pc = got_pc.pop_front(); ins = got_instr.pop_front();
         total++; if (pc !== exp_pc || ins !== mem_word(exp_pc)) begin
            bad++; $display("FAIL mr_item pc=%h instr=%h want pc=%h instr=%h", pc, ins, exp_pc, mem_word(exp_pc));
         end
         exp_pc += 32'd4;
      end
   endtask

   initial begin
      test_reset();
      test_mem_stall();
      test_sequential();
      test_backpressure();
      test_redirect_inflight();
      test_wrap();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
